// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and coordinate width for the display
// pipeline stages.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int HD = 640;
  localparam int HF = 16;
  localparam int HR = 96;
  localparam int HB = 48;
  localparam int VD = 480;
  localparam int VF = 10;
  localparam int VR = 2;
  localparam int VB = 33;

  localparam logic [COORD_W-1:0] H_MAX       = COORD_W'(HD + HF + HR + HB - 1);
  localparam logic [COORD_W-1:0] V_MAX       = COORD_W'(VD + VF + VR + VB - 1);
  localparam logic [COORD_W-1:0] HSYNC_START = COORD_W'(HD + HF);
  localparam logic [COORD_W-1:0] HSYNC_END   = COORD_W'(HD + HF + HR - 1);
  localparam logic [COORD_W-1:0] VSYNC_START = COORD_W'(VD + VF);
  localparam logic [COORD_W-1:0] VSYNC_END   = COORD_W'(VD + VF + VR - 1);

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel-rate clock enable: one-clk p_tick every CLK_DIV system clocks.
// Shared by the sync, text and color stages so they all step together.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                div <= '0;
    else if (div == DIV_LAST) div <= '0;
    else                      div <= div + 1'b1;
  end

  // Decoded from the registered count so reset clears it immediately.
  assign p_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with registered sync and blanking.
// Define VGA_FRAME_TICK_EN to add the one-clk frame_start output.
module vga_sync_gen #(
  parameter int HD      = vga_pkg::HD,
  parameter int HF      = vga_pkg::HF,
  parameter int HR      = vga_pkg::HR,
  parameter int HB      = vga_pkg::HB,
  parameter int VD      = vga_pkg::VD,
  parameter int VF      = vga_pkg::VF,
  parameter int VR      = vga_pkg::VR,
  parameter int VB      = vga_pkg::VB,
  parameter int CLK_DIV = 4
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef VGA_FRAME_TICK_EN
  output logic                          frame_start,
`endif
  output logic                          hsync,
  output logic                          vsync,
  output logic                          video_on,
  output logic                          p_tick,
  output logic [vga_pkg::COORD_W-1:0]   pixel_x,
  output logic [vga_pkg::COORD_W-1:0]   pixel_y
);

  import vga_pkg::*;

  localparam logic [COORD_W-1:0] H_MAX       = COORD_W'(HD + HF + HR + HB - 1);
  localparam logic [COORD_W-1:0] V_MAX       = COORD_W'(VD + VF + VR + VB - 1);
  localparam logic [COORD_W-1:0] H_VIS       = COORD_W'(HD);
  localparam logic [COORD_W-1:0] V_VIS       = COORD_W'(VD);
  localparam logic [COORD_W-1:0] HSYNC_START = COORD_W'(HD + HF);
  localparam logic [COORD_W-1:0] HSYNC_END   = COORD_W'(HD + HF + HR - 1);
  localparam logic [COORD_W-1:0] VSYNC_START = COORD_W'(VD + VF);
  localparam logic [COORD_W-1:0] VSYNC_END   = COORD_W'(VD + VF + VR - 1);

  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic               h_wrap, v_wrap;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  always_comb begin
    h_wrap = (pixel_x == H_MAX);
    v_wrap = (pixel_y == V_MAX);
    x_nxt  = h_wrap ? '0 : pixel_x + 1'b1;
    y_nxt  = pixel_y;
    if (h_wrap) y_nxt = v_wrap ? '0 : pixel_y + 1'b1;
  end

  // Sync/blank are decoded from the next coordinates so they land in the
  // same cycle as the counters they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_x  <= '0;
      pixel_y  <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else if (p_tick) begin
      pixel_x  <= x_nxt;
      pixel_y  <= y_nxt;
      hsync    <= !((x_nxt >= HSYNC_START) && (x_nxt <= HSYNC_END));
      vsync    <= !((y_nxt >= VSYNC_START) && (y_nxt <= VSYNC_END));
      video_on <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
    end
  end

`ifdef VGA_FRAME_TICK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_start <= 1'b0;
    else       frame_start <= p_tick && h_wrap && v_wrap;
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size 640x480 instance plus a tiny-timing
// instance so whole frames fit in a short run; tick-count reference model.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       fs;
  } obs_t;

  logic       clk, rst;
  logic       m_hs, m_vs, m_von, m_pt, m_fs;
  logic       s_hs, s_vs, s_von, s_pt, s_fs;
  logic [9:0] m_x, m_y, s_x, s_y;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_sb    = 0;
  int   kclk    = 0;
  bit   sb_on   = 0;
  obs_t q_m[$];
  obs_t q_s[$];

  localparam obs_t RST_OBS = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b0, pt: 1'b0, fs: 1'b0};

  vga_sync_gen dut_m (
    .clk         (clk),
    .reset       (rst),
`ifdef VGA_FRAME_TICK_EN
    .frame_start (m_fs),
`endif
    .hsync       (m_hs),
    .vsync       (m_vs),
    .video_on    (m_von),
    .p_tick      (m_pt),
    .pixel_x     (m_x),
    .pixel_y     (m_y)
  );

  vga_sync_gen #(
    .HD(8), .HF(2), .HR(3), .HB(2), .VD(4), .VF(1), .VR(2), .VB(1), .CLK_DIV(2)
  ) dut_s (
    .clk         (clk),
    .reset       (rst),
`ifdef VGA_FRAME_TICK_EN
    .frame_start (s_fs),
`endif
    .hsync       (s_hs),
    .vsync       (s_vs),
    .video_on    (s_von),
    .p_tick      (s_pt),
    .pixel_x     (s_x),
    .pixel_y     (s_y)
  );

`ifndef VGA_FRAME_TICK_EN
  assign m_fs = 1'b0;
  assign s_fs = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected state after the k-th rising edge since reset release.
  function automatic obs_t expect_obs(int k, int div, int hd, int hf, int hr, int hb,
                                      int vd, int vf, int vr, int vb);
    obs_t o;
    int ht, vt, n, x, y;
    ht = hd + hf + hr + hb;
    vt = vd + vf + vr + vb;
    n  = k / div;
    x  = n % ht;
    y  = (n / ht) % vt;
    o.x   = 10'(x);
    o.y   = 10'(y);
    o.hs  = !(x >= hd + hf && x < hd + hf + hr);
    o.vs  = !(y >= vd + vf && y < vd + vf + vr);
    o.von = (n != 0) && (x < hd) && (y < vd);
    o.pt  = (k % div) == div - 1;
`ifdef VGA_FRAME_TICK_EN
    o.fs  = (k % div == 0) && (n != 0) && (n % (ht * vt) == 0);
`else
    o.fs  = 1'b0;
`endif
    return o;
  endfunction

  function automatic obs_t obs_m();
    return '{x: m_x, y: m_y, hs: m_hs, vs: m_vs, von: m_von, pt: m_pt, fs: m_fs};
  endfunction

  function automatic obs_t obs_s();
    return '{x: s_x, y: s_y, hs: s_hs, vs: s_vs, von: s_von, pt: s_pt, fs: s_fs};
  endfunction

  // Scoreboard producer: expectations pushed at each rising edge.
  initial forever begin
    @(posedge clk);
    if (sb_on) begin
      kclk++;
      q_m.push_back(expect_obs(kclk, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      q_s.push_back(expect_obs(kclk, 2, 8, 2, 3, 2, 4, 1, 2, 1));
    end
  end

  // Scoreboard consumer: compared on the falling edge.
  initial forever begin
    obs_t e, o;
    @(negedge clk);
    if (sb_on && q_m.size() > 0 && q_s.size() > 0) begin
      e = q_m.pop_front();
      o = obs_m();
      n_tests++; n_sb++;
      if (o !== e) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL sb_main got x=%0d y=%0d hs%b vs%b von%b pt%b fs%b want x=%0d y=%0d hs%b vs%b von%b pt%b fs%b",
          o.x, o.y, o.hs, o.vs, o.von, o.pt, o.fs, e.x, e.y, e.hs, e.vs, e.von, e.pt, e.fs);
      end
      e = q_s.pop_front();
      o = obs_s();
      n_tests++; n_sb++;
      if (o !== e) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL sb_small got x=%0d y=%0d hs%b vs%b von%b pt%b fs%b want x=%0d y=%0d hs%b vs%b von%b pt%b fs%b",
          o.x, o.y, o.hs, o.vs, o.von, o.pt, o.fs, e.x, e.y, e.hs, e.vs, e.von, e.pt, e.fs);
      end
    end
  end

  task automatic release_reset();
    @(negedge clk);
    rst   = 1'b0;
    kclk  = 0;
    q_m.delete();
    q_s.delete();
    sb_on = 1'b1;
  endtask

  task automatic wait_m(input int x, input int y, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_x == 10'(x) && m_y == 10'(y)) begin hit = 1'b1; break; end
    end
  endtask

  task automatic wait_s(input int x, input int y, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (s_x == 10'(x) && s_y == 10'(y)) begin hit = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_m() !== RST_OBS || obs_s() !== RST_OBS) begin
        n_fail++;
        $display("FAIL reset_hold clk=%0d main=%h small=%h want %h", i, obs_m(), obs_s(), RST_OBS);
      end
    end
    release_reset();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (m_pt !== ((i % 4) == 3)) begin
        n_fail++;
        $display("FAIL p_tick_phase clk=%0d got %b want %b", i, m_pt, (i % 4) == 3);
      end
    end
  endtask

  task automatic test_line();
    bit hit;
    wait_m(639, 0, 4000, hit); n_tests++;
    if (!hit || m_von !== 1'b1) begin n_fail++; $display("FAIL line_x639 hit=%0d video_on=%b want 1", hit, m_von); end
    wait_m(640, 0, 100, hit); n_tests++;
    if (!hit || m_von !== 1'b0) begin n_fail++; $display("FAIL line_x640 hit=%0d video_on=%b want 0", hit, m_von); end
    wait_m(655, 0, 100, hit); n_tests++;
    if (!hit || m_hs !== 1'b1) begin n_fail++; $display("FAIL hsync_655 hit=%0d hsync=%b want 1", hit, m_hs); end
    wait_m(656, 0, 100, hit); n_tests++;
    if (!hit || m_hs !== 1'b0) begin n_fail++; $display("FAIL hsync_656 hit=%0d hsync=%b want 0", hit, m_hs); end
    wait_m(751, 0, 400, hit); n_tests++;
    if (!hit || m_hs !== 1'b0) begin n_fail++; $display("FAIL hsync_751 hit=%0d hsync=%b want 0", hit, m_hs); end
    wait_m(752, 0, 100, hit); n_tests++;
    if (!hit || m_hs !== 1'b1) begin n_fail++; $display("FAIL hsync_752 hit=%0d hsync=%b want 1", hit, m_hs); end
    wait_m(799, 0, 400, hit); n_tests++;
    if (!hit || m_von !== 1'b0) begin n_fail++; $display("FAIL line_x799 hit=%0d video_on=%b want 0", hit, m_von); end
    wait_m(0, 1, 100, hit); n_tests++;
    if (!hit || m_von !== 1'b1 || m_hs !== 1'b1 || m_vs !== 1'b1) begin
      n_fail++; $display("FAIL line_wrap hit=%0d von=%b hs=%b vs=%b want 1 1 1", hit, m_von, m_hs, m_vs);
    end
  endtask

  task automatic test_frame();
    bit hit;
    int fs_cnt;
    rst   = 1'b1;
    sb_on = 1'b0;
    repeat (3) @(negedge clk);
    release_reset();
    repeat (239) @(negedge clk);
    n_tests++;
    if (s_x !== 10'd14 || s_y !== 10'd7 || s_pt !== 1'b1 || s_fs !== 1'b0) begin
      n_fail++; $display("FAIL frame_last got (%0d,%0d) pt=%b fs=%b want (14,7) 1 0", s_x, s_y, s_pt, s_fs);
    end
    @(negedge clk);
    n_tests++;
    if (s_x !== 10'd0 || s_y !== 10'd0 || s_von !== 1'b1 || s_vs !== 1'b1) begin
      n_fail++; $display("FAIL frame_wrap got (%0d,%0d) von=%b vs=%b want (0,0) 1 1", s_x, s_y, s_von, s_vs);
    end
`ifdef VGA_FRAME_TICK_EN
    n_tests++;
    if (s_fs !== 1'b1) begin n_fail++; $display("FAIL frame_start_hi got %b want 1", s_fs); end
    @(negedge clk);
    n_tests++;
    if (s_fs !== 1'b0) begin n_fail++; $display("FAIL frame_start_lo got %b want 0", s_fs); end
`endif
    wait_s(10, 0, 100, hit); n_tests++;
    if (!hit || s_hs !== 1'b0) begin n_fail++; $display("FAIL small_hsync hit=%0d hsync=%b want 0", hit, s_hs); end
    wait_s(14, 4, 200, hit); n_tests++;
    if (!hit || s_vs !== 1'b1) begin n_fail++; $display("FAIL vsync_pre hit=%0d vsync=%b want 1", hit, s_vs); end
    wait_s(0, 5, 10, hit); n_tests++;
    if (!hit || s_vs !== 1'b0) begin n_fail++; $display("FAIL vsync_fall hit=%0d vsync=%b want 0", hit, s_vs); end
    wait_s(14, 6, 100, hit); n_tests++;
    if (!hit || s_vs !== 1'b0) begin n_fail++; $display("FAIL vsync_hold hit=%0d vsync=%b want 0", hit, s_vs); end
    wait_s(0, 7, 10, hit); n_tests++;
    if (!hit || s_vs !== 1'b1) begin n_fail++; $display("FAIL vsync_rise hit=%0d vsync=%b want 1", hit, s_vs); end
    // Two full small frames: exactly two frame_start pulses expected.
    fs_cnt = 0;
    for (int i = 0; i < 480; i++) begin
      @(negedge clk);
      if (s_fs === 1'b1) fs_cnt++;
    end
    n_tests++;
`ifdef VGA_FRAME_TICK_EN
    if (fs_cnt != 2) begin n_fail++; $display("FAIL frame_start_count got %0d want 2", fs_cnt); end
`else
    if (fs_cnt != 0) begin n_fail++; $display("FAIL frame_start_count got %0d want 0", fs_cnt); end
`endif
  endtask

  task automatic test_async_reset();
    bit hit;
    wait_m(300, 0, 2000, hit); n_tests++;
    if (!hit) begin n_fail++; $display("FAIL reach_x300 timed out at (%0d,%0d)", m_x, m_y); end
    @(posedge clk);
    #3;
    sb_on = 1'b0;
    q_m.delete();
    q_s.delete();
    rst = 1'b1;
    #1;
    n_tests++;
    if (obs_m() !== RST_OBS || obs_s() !== RST_OBS) begin
      n_fail++; $display("FAIL async_reset main=%h small=%h want %h", obs_m(), obs_s(), RST_OBS);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs_m() !== RST_OBS || obs_s() !== RST_OBS) begin
      n_fail++; $display("FAIL reset_held main=%h small=%h want %h", obs_m(), obs_s(), RST_OBS);
    end
    release_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (m_x !== 10'd0 || m_y !== 10'd0 || m_von !== 1'b0 || m_pt !== 1'b1) begin
      n_fail++; $display("FAIL restart_pre got (%0d,%0d) von=%b pt=%b want (0,0) 0 1", m_x, m_y, m_von, m_pt);
    end
    @(negedge clk);
    n_tests++;
    if (m_x !== 10'd1 || m_y !== 10'd0 || m_von !== 1'b1 || m_pt !== 1'b0) begin
      n_fail++; $display("FAIL restart_first got (%0d,%0d) von=%b pt=%b want (1,0) 1 0", m_x, m_y, m_von, m_pt);
    end
    repeat (600) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_line();
    test_frame();
    test_async_reset();
    sb_on = 1'b0;
    n_tests++;
    if (n_sb < 1000) begin n_fail++; $display("FAIL sb_coverage got %0d want >=1000", n_sb); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
